usr_param: RTL and testbench
============================

// Module: usr_param
// PURPOSE
//  Parametrised universal shift register, the successor to the fixed 4-bit USR.
//  Adds a WIDTH parameter, 8 modes (rotate, arithmetic shift, clear), a carry-out,
//  and a multi-position burst-shift engine with a busy/done handshake.
//  Used as the datapath shifter behind serial links and the ALU shift path.
// PARAMETERS
//  WIDTH  8                     register width in bits, >= 2
//  SHW    $clog2(WIDTH+1)       width of shamt; holds values 0..WIDTH
// PORTS
//  clk    in   1      rising-edge clock; the block's only clock
//  reset  in   1      asynchronous, active-low reset
//  en     in   1      single-op enable, used only in IDLE
//  s      in   3      mode select (see BEHAVIOUR)
//  I      in   WIDTH  parallel load data
//  SINR   in   1      serial in for shift right (enters at MSB)
//  SINL   in   1      serial in for shift left (enters at LSB)
//  start  in   1      start a burst of shamt shifts in mode s
//  shamt  in   SHW    burst length; values above WIDTH clamp to WIDTH
//  O      out  WIDTH  register contents
//  carry  out  1      last bit shifted or rotated out
//  busy   out  1      burst in progress
//  done   out  1      one-cycle pulse when a burst completes
//  parity out  1      present only with USR_PARITY_EN
// BEHAVIOUR
//  Reset (reset=0, async): O=0, carry=0, busy=0, done=0, count=0, FSM=IDLE, parity=0.
//    Applies immediately, including mid-burst. The aborted burst does not pulse done.
//  Modes (s):
//    000 hold
//    001 shift right: O <= {SINR, O[W-1:1]}, carry <= O[0]
//    010 shift left:  O <= {O[W-2:0], SINL}, carry <= O[W-1]
//    011 load:        O <= I
//    100 rotate right: O <= {O[0], O[W-1:1]}, carry <= O[0]
//    101 rotate left:  O <= {O[W-2:0], O[W-1]}, carry <= O[W-1]
//    110 arithmetic shift right: O <= {O[W-1], O[W-1:1]}, carry <= O[0]
//    111 clear: O <= 0
//  carry changes only on shift/rotate modes. Hold, load and clear leave it unchanged.
//  FSM IDLE:
//    start=1 with s in {001,010,100,101,110} -> accept the burst.
//      Latch mode=s, count=min(shamt,WIDTH). No shift on the accepting edge.
//      count>0 -> go to BUSY.
//      count==0 -> stay in IDLE and pulse done=1 on the next edge; O is unchanged.
//    start=1 with a non-shift mode -> start is ignored; the normal op is applied if en=1.
//    start=0 -> if en=1, apply mode s once per edge; if en=0, hold.
//    A start that is accepted takes priority over the single op on that edge.
//  FSM BUSY (busy=1):
//    Each edge performs one op of the latched mode and does count--.
//    en, s, I, start and shamt are ignored.
//    The edge where count goes 1->0 returns to IDLE, sets busy=0 and done=1.
//    O and carry hold their final values in the done cycle.
//  Latency: start accepted at edge k -> shifts at edges k+1..k+N -> done high after edge k+N.
//  A start in the done cycle is accepted normally, so back-to-back bursts work.
//  busy and done are registered outputs. done is never high together with busy.
// CONFIGURATION
//  USR_PARITY_EN defined: parity output exists and is registered alongside O (parity == ^O).
//    It reads 0 after reset and updates on the same edge as O.
//  USR_PARITY_EN undefined: the parity port and its logic are removed. All other behaviour is identical.
// TESTING  (WIDTH=8)
//  1 Reset, then en=1, s=011, I=8'hA5 -> O=8'hA5 on the next edge. en=0 -> O holds.
//  2 O=8'h81: s=001, SINR=0 -> O=8'h40, carry=1. s=110 from 8'h81 -> 8'hC0, carry=1.
//  3 O=8'h96: start=1, s=101, shamt=3 -> busy for 3 cycles, O=8'hB4, carry=0, done pulses once.
//  4 shamt=0 start -> done after 1 edge, busy never set, O unchanged.
//    shamt=15 -> clamped to 8 shifts; rotate returns the original O.
//  5 Mid-burst, toggle s, I and start -> no effect.
//    Assert reset mid-burst -> O=0, busy=0, no done.
//  6 Back-to-back: start during the done cycle -> new burst accepted with no idle gap.
//    With USR_PARITY_EN, parity==^O on every cycle.

Source files
------------

// File: rtl/usr_param.sv
// rtl/usr_param.sv - parametrised universal shift register with burst-shift engine
//
// Purpose: WIDTH-bit universal shift register with eight modes (hold, shift
//   right/left, load, rotate right/left, arithmetic shift right, clear), a carry
//   out, and a multi-position burst-shift engine with a busy/done handshake.
// Optional feature macro: USR_PARITY_EN adds a registered parity output (^O).
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-low reset
//   en     in   1      single-op enable (IDLE only)
//   s      in   3      mode select
//   I      in   WIDTH  parallel load data
//   SINR   in   1      serial in for shift right (enters at MSB)
//   SINL   in   1      serial in for shift left (enters at LSB)
//   start  in   1      start a burst of shamt shifts in mode s
//   shamt  in   SHW    burst length, clamped to WIDTH
//   O      out  WIDTH  register contents
//   carry  out  1      last bit shifted or rotated out
//   busy   out  1      burst in progress
//   done   out  1      one-cycle pulse when a burst completes
//   parity out  1      ^O, only with USR_PARITY_EN
module usr_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] I,
  input  logic             SINR,
  input  logic             SINL,
  input  logic             start,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] O,
  output logic             carry,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_n;
  logic [SHW-1:0]   count_q, count_n;
  logic [2:0]       mode_q, mode_n;
  logic [WIDTH-1:0] o_n;
  logic             carry_n;
  logic             done_n;

  logic [2:0]       op_sel;
  logic             op_en;
  logic [WIDTH-1:0] shifted;
  logic             shift_c;
  logic             c_upd;
  logic             is_shift;
  logic [SHW-1:0]   clamped;

  assign is_shift = (s == 3'b001) || (s == 3'b010) || (s == 3'b100) ||
                    (s == 3'b101) || (s == 3'b110);
  assign clamped  = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
  assign busy     = (state_q == BUSY);

  // Datapath: result of one op of mode op_sel applied to the current O.
  always_comb begin
    shifted = O;
    shift_c = carry;
    c_upd   = 1'b0;
    case (op_sel)
      3'b001: begin shifted = {SINR, O[WIDTH-1:1]};     shift_c = O[0];       c_upd = 1'b1; end
      3'b010: begin shifted = {O[WIDTH-2:0], SINL};     shift_c = O[WIDTH-1]; c_upd = 1'b1; end
      3'b011: shifted = I;
      3'b100: begin shifted = {O[0], O[WIDTH-1:1]};     shift_c = O[0];       c_upd = 1'b1; end
      3'b101: begin shifted = {O[WIDTH-2:0], O[WIDTH-1]}; shift_c = O[WIDTH-1]; c_upd = 1'b1; end
      3'b110: begin shifted = {O[WIDTH-1], O[WIDTH-1:1]}; shift_c = O[0];     c_upd = 1'b1; end
      3'b111: shifted = '0;
      default: ;
    endcase
  end

  // Control: an accepted burst start outranks the single op; in BUSY the
  // latched mode drives the datapath and all request inputs are ignored.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    mode_n  = mode_q;
    done_n  = 1'b0;
    op_sel  = s;
    op_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && is_shift) begin
          mode_n  = s;
          count_n = clamped;
          if (clamped == '0) done_n = 1'b1;   // zero-length burst completes at once
          else               state_n = BUSY;
        end else if (en) begin
          op_en = 1'b1;
        end
      end
      BUSY: begin
        op_sel  = mode_q;
        op_en   = 1'b1;
        count_n = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    o_n     = op_en ? shifted : O;
    carry_n = (op_en && c_upd) ? shift_c : carry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= '0;
      O       <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      mode_q  <= mode_n;
      O       <= o_n;
      carry   <= carry_n;
      done    <= done_n;
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity <= 1'b0;
    else        parity <= ^o_n;
  end
`endif

endmodule

// File: tb/tb_usr_param.sv
// tb/tb_usr_param.sv - scoreboard testbench for usr_param (WIDTH=8)
module tb_usr_param;
  localparam int W = 8;
  localparam int SW = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic [2:0]    s;
  logic [W-1:0]  I;
  logic          SINR;
  logic          SINL;
  logic          start;
  logic [SW-1:0] shamt;
  logic [W-1:0]  O;
  logic          carry;
  logic          busy;
  logic          done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  usr_param #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .reset(reset), .en(en), .s(s), .I(I), .SINR(SINR), .SINL(SINL),
    .start(start), .shamt(shamt), .O(O), .carry(carry), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int o;
    int c;
    int b;
    int d;
    int p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: register value, carry, remaining burst shifts.
  int m_o, m_c, m_rem, m_mode, m_done;
  localparam int MASK = (1 << W) - 1;
  localparam int MSB  = 1 << (W - 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int par(input int v);
    int r = 0;
    for (int i = 0; i < W; i++) r ^= (v >> i) & 1;
    return r;
  endfunction

  task automatic apply(input int mode);
    case (mode)
      1: begin m_c = m_o & 1; m_o = (m_o >> 1) | (SINR ? MSB : 0); end
      2: begin m_c = (m_o >> (W-1)) & 1; m_o = ((m_o << 1) | int'(SINL)) & MASK; end
      3: m_o = int'(I);
      4: begin m_c = m_o & 1; m_o = (m_o >> 1) | (m_c * MSB); end
      5: begin m_c = (m_o >> (W-1)) & 1; m_o = ((m_o << 1) | m_c) & MASK; end
      6: begin m_c = m_o & 1; m_o = (m_o >> 1) | (m_o & MSB); end
      7: m_o = 0;
      default: ;
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.o = m_o; e.c = m_c; e.b = (m_rem > 0) ? 1 : 0; e.d = m_done; e.p = par(m_o);
    q.push_back(e);
  endtask

  task automatic model_edge();
    int n;
    if (m_rem > 0) begin
      apply(m_mode);
      m_rem--;
      m_done = (m_rem == 0) ? 1 : 0;
    end else begin
      m_done = 0;
      if (start && (s inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        n = (int'(shamt) > W) ? W : int'(shamt);
        if (n == 0) m_done = 1;
        else begin m_rem = n; m_mode = int'(s); end
      end else if (en) begin
        apply(int'(s));
      end
    end
  endtask

  task automatic step(input logic e, input logic [2:0] ss, input logic [W-1:0] ii,
                      input logic sr, input logic sl, input logic st, input logic [SW-1:0] sh);
    en = e; s = ss; I = ii; SINR = sr; SINL = sl; start = st; shamt = sh;
    model_edge();
    push_exp();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 3'd0, 8'h00, 0, 0, 0, 4'd0);
  endtask

  task automatic rnd_step();
    step(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
         ($urandom_range(0, 3) == 0), 4'($urandom));
  endtask

  // Reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_o = 0; m_c = 0; m_rem = 0; m_mode = 0; m_done = 0;
    push_exp();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_O", 32'(O), 32'(e.o));
        chk("sb_carry", 32'(carry), 32'(e.c));
        chk("sb_busy", 32'(busy), 32'(e.b));
        chk("sb_done", 32'(done), 32'(e.d));
`ifdef USR_PARITY_EN
        chk("sb_parity", 32'(parity), 32'(e.p));
`endif
      end
    end
  end

  initial begin
    int orig;
    reset = 1'b0; en = 0; s = 0; I = 0; SINR = 0; SINL = 0; start = 0; shamt = 0;
    m_o = 0; m_c = 0; m_rem = 0; m_mode = 0; m_done = 0;
    push_exp();
    @(posedge clk);
    #2;
    chk("reset_O", 32'(O), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // Load and hold
    step(1, 3'b011, 8'hA5, 0, 0, 0, 0);
    chk("load_A5", 32'(O), 32'hA5);
    step(0, 3'b001, 8'h00, 1, 1, 0, 0);
    chk("hold_A5", 32'(O), 32'hA5);

    // Shift right and arithmetic shift right from 0x81
    step(1, 3'b011, 8'h81, 0, 0, 0, 0);
    step(1, 3'b001, 8'h00, 0, 0, 0, 0);
    chk("shr_O", 32'(O), 32'h40);
    chk("shr_carry", 32'(carry), 32'h1);
    step(1, 3'b011, 8'h81, 0, 0, 0, 0);
    step(1, 3'b110, 8'h00, 0, 0, 0, 0);
    chk("asr_O", 32'(O), 32'hC0);
    chk("asr_carry", 32'(carry), 32'h1);

    // Burst rotate left by 3 from 0x96
    step(1, 3'b011, 8'h96, 0, 0, 0, 0);
    step(0, 3'b101, 8'h00, 0, 0, 1, 4'd3);
    chk("burst_busy", 32'(busy), 32'h1);
    idle(3);
    chk("burst_O", 32'(O), 32'hB4);
    chk("burst_carry", 32'(carry), 32'h0);
    chk("burst_done", 32'(done), 32'h1);
    chk("burst_busy_off", 32'(busy), 32'h0);
    idle(1);
    chk("burst_done_pulse", 32'(done), 32'h0);

    // Zero-length burst, then clamped full rotation
    step(0, 3'b001, 8'h00, 0, 0, 1, 4'd0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_O", 32'(O), 32'hB4);
    orig = 32'hB4;
    step(0, 3'b100, 8'h00, 0, 0, 1, 4'd15);
    idle(7);
    chk("clamp_not_done", 32'(done), 32'h0);
    idle(1);
    chk("clamp_O", 32'(O), 32'(orig));
    chk("clamp_done", 32'(done), 32'h1);

    // Inputs ignored mid-burst, then reset mid-burst
    step(0, 3'b010, 8'h00, 0, 1, 1, 4'd6);
    for (int k = 0; k < 3; k++) rnd_step();
    do_reset();
    chk("midrst_O", 32'(O), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    idle(2);
    chk("midrst_no_done", 32'(done), 32'h0);

    // Back-to-back bursts
    step(1, 3'b011, 8'h3C, 0, 0, 0, 0);
    step(0, 3'b010, 8'h00, 0, 1, 1, 4'd2);
    idle(2);
    chk("b2b_done1", 32'(done), 32'h1);
    step(0, 3'b001, 8'h00, 1, 0, 1, 4'd1);
    chk("b2b_busy2", 32'(busy), 32'h1);
    idle(1);
    chk("b2b_done2", 32'(done), 32'h1);

    // Randomised traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else rnd_step();
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
